// File: rtl/rr_arbiter_16.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_16
//  Purpose  : Round-robin arbiter sharing one downstream resource between 16
//             requesters. Priority rotates via a thermometer mask built from
//             the last-granted index. A grant is held until the owner releases
//             it or drops its request. A grant held for MAX_HOLD cycles is
//             forcibly revoked so a stuck owner cannot starve the others.
//  Ports    : clk          rising-edge clock
//             rst          asynchronous active-high reset
//             req[N]       level-sensitive request vector
//             rel          owner done (sampled only while grant_valid=1);
//                          named rel because "release" is a reserved word
//             grant[N]     registered one-hot grant
//             grant_idx    registered binary index of the granted requester
//             grant_valid  high while a grant is held
//             timeout      one-cycle pulse on a forced revoke
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_16 #(
    parameter int N        = 16,
    parameter int LOG_N    = 4,
    parameter int MAX_HOLD = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             rel,
    output logic [N-1:0]     grant,
    output logic [LOG_N-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0]       c_max_hold = 8'(MAX_HOLD);
    localparam logic [LOG_N-1:0] c_last_rst = LOG_N'(N - 1);
    localparam logic [N-1:0]     c_one      = N'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state_q,       state_d;
    logic [LOG_N-1:0] last_idx_q,    last_idx_d;
    logic [7:0]       hold_cnt_q,    hold_cnt_d;
    logic [N-1:0]     grant_q,       grant_d;
    logic [LOG_N-1:0] grant_idx_q,   grant_idx_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q,     timeout_d;

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_masked;
    logic [LOG_N-1:0] w_masked_idx;
    logic [LOG_N-1:0] w_req_idx;
    logic [LOG_N-1:0] w_winner;
    logic             w_owner_req;

    // Thermometer mask: only requesters strictly above the last owner are
    // preferred, so the last owner itself ends up with the lowest priority.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign w_mask[gi] = (LOG_N'(gi) > last_idx_q);
        end
    endgenerate

    assign w_masked = req & w_mask;

    function automatic logic [LOG_N-1:0] lowest_set(input logic [N-1:0] v);
        logic [LOG_N-1:0] idx;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = LOG_N'(i);
            end
        end
        return idx;
    endfunction

    assign w_masked_idx = lowest_set(w_masked);
    assign w_req_idx    = lowest_set(req);
    // Nothing above the last owner is requesting: wrap to the bottom.
    assign w_winner     = (|w_masked) ? w_masked_idx : w_req_idx;
    assign w_owner_req  = req[grant_idx_q];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_idx_d    = last_idx_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;          // pulse lasts exactly one cycle

        unique case (state_q)
            ST_IDLE: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                if (|req) begin
                    grant_d       = c_one << w_winner;
                    grant_idx_d   = w_winner;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = 8'd1;
                    state_d       = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Release wins over a coincident timeout, so no timeout
                // pulse is produced when the owner gives up on the last cycle.
                if (rel || !w_owner_req) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    last_idx_d    = grant_idx_q;
                    state_d       = ST_IDLE;
                end else if (hold_cnt_q == c_max_hold) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                    last_idx_d    = grant_idx_q;
                    state_d       = ST_IDLE;
                end else begin
                    hold_cnt_d    = hold_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_idx_q    <= c_last_rst;   // first arbitration favours req[0]
            hold_cnt_q    <= 8'd0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_idx_q    <= last_idx_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire
